// File: rtl/rst_seq.sv
// Reset sequencer: synchronises ext_rst_n, holds, then releases channels in order.
// Optional per-channel ack handshake with timeout enabled by RST_SEQ_ACK_EN.
module rst_seq #(
  parameter int NCH         = 4,
  parameter int SYNC_DEPTH  = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 64,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_rst_n,
  input  logic            sw_rst_req,
`ifdef RST_SEQ_ACK_EN
  input  logic [NCH-1:0]  ch_ack,
  output logic            seq_err,
`endif
  output logic [NCH-1:0]  rst_n_out,
  output logic            seq_done,
  output logic [CH_W-1:0] cur_ch
);

  typedef enum logic [1:0] {
    S_ASSERT,
    S_RELEASE,
    S_RUN
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NCH - 1);

  logic [SYNC_DEPTH-1:0] sync_q;
  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NCH-1:0]        rst_n_q;
  logic                  done_q;
  logic [CH_W-1:0]       cur_q;

  logic ext_sync;
  logic abort;
  logic gap_ok;
  logic rel;

`ifdef RST_SEQ_ACK_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
  logic [CNT_W-1:0] wcnt_q;
  logic             err_q;
  logic [CH_W-1:0]  prev_ch;
  logic             ack_k;
  logic             tmo;
`endif

  assign ext_sync = sync_q[SYNC_DEPTH-1];
  assign abort    = !ext_sync || sw_rst_req;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_DEPTH-2:0], ext_rst_n};
  end

  always_comb begin
    gap_ok = (cnt_q == GAP_LAST);
`ifdef RST_SEQ_ACK_EN
    prev_ch = cur_q - CH_W'(1);
    ack_k   = ch_ack[prev_ch];
    tmo     = (wcnt_q == TMO_LAST);
    rel     = gap_ok && (ack_k || tmo);
`else
    rel     = gap_ok;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ASSERT;
      cnt_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cur_q   <= '0;
`ifdef RST_SEQ_ACK_EN
      wcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else if (abort) begin
      // abort wins over any release due on this edge; seq_err is kept
      state_q <= S_ASSERT;
      cnt_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cur_q   <= '0;
`ifdef RST_SEQ_ACK_EN
      wcnt_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        S_ASSERT: begin
          if (cnt_q == HOLD_LAST) begin
            rst_n_q[0] <= 1'b1;
            cnt_q      <= '0;
`ifdef RST_SEQ_ACK_EN
            wcnt_q     <= '0;
`endif
            if (NCH == 1) begin
              state_q <= S_RUN;
              done_q  <= 1'b1;
              cur_q   <= '0;
            end else begin
              state_q <= S_RELEASE;
              cur_q   <= CH_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
`ifdef RST_SEQ_ACK_EN
          if (tmo && !ack_k) err_q <= 1'b1;
`endif
          if (rel) begin
            rst_n_q[cur_q] <= 1'b1;
            cnt_q          <= '0;
`ifdef RST_SEQ_ACK_EN
            wcnt_q         <= '0;
`endif
            if (cur_q == LAST_CH) begin
              state_q <= S_RUN;
              done_q  <= 1'b1;
            end else begin
              cur_q <= cur_q + CH_W'(1);
            end
          end else begin
            if (!gap_ok) cnt_q <= cnt_q + CNT_W'(1);
`ifdef RST_SEQ_ACK_EN
            if (!tmo) wcnt_q <= wcnt_q + CNT_W'(1);
`endif
          end
        end
        S_RUN: begin
          rst_n_q <= '1;
          done_q  <= 1'b1;
          cur_q   <= LAST_CH;
        end
        default: state_q <= S_ASSERT;
      endcase
    end
  end

  assign rst_n_out = rst_n_q;
  assign seq_done  = done_q;
  assign cur_ch    = cur_q;
`ifdef RST_SEQ_ACK_EN
  assign seq_err   = err_q;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: edge-indexed expectations queued and checked per cycle.
module tb_rst_seq;

  localparam int NCH  = 4;
  localparam int SD   = 2;
  localparam int HOLD = 16;
  localparam int GAP  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ext_rst_n = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [3:0] rst_n_out;
  logic       seq_done;
  logic [1:0] cur_ch;
`ifdef RST_SEQ_ACK_EN
  logic [3:0] ch_ack = 4'hF;
  logic       seq_err;
`endif

  rst_seq #(
    .NCH(NCH), .SYNC_DEPTH(SD), .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAP), .CNT_W(8), .ACK_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ext_rst_n(ext_rst_n),
    .sw_rst_req(sw_rst_req),
`ifdef RST_SEQ_ACK_EN
    .ch_ack(ch_ack),
    .seq_err(seq_err),
`endif
    .rst_n_out(rst_n_out),
    .seq_done(seq_done),
    .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  int edge_n;
  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  typedef struct {
    int         e;
    logic [3:0] rn;
    logic       dn;
    logic [1:0] cc;
    logic       er;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic exp_err = 1'b0;

  task automatic push(input int e, input logic [3:0] rn,
                      input logic dn, input logic [1:0] cc);
    exp_t x;
    x.e = e; x.rn = rn; x.dn = dn; x.cc = cc; x.er = exp_err;
    sb.push_back(x);
  endtask

  // channel k releases at E+HOLD+k*GAP; also check the edge before
  task automatic push_seq(input int base);
    for (int k = 0; k < NCH; k++) begin
      int t;
      t = base + HOLD + k * GAP;
      push(t - 1, 4'((1 << k) - 1), 1'b0, 2'(k));
      push(t, 4'((1 << (k + 1)) - 1), k == NCH - 1,
           2'((k == NCH - 1) ? k : k + 1));
    end
  endtask

  task automatic sb_drain(input int upto);
    exp_t x;
    while (edge_n < upto) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].e <= edge_n) begin
        x = sb.pop_front();
        checks++;
        if (rst_n_out !== x.rn || seq_done !== x.dn || cur_ch !== x.cc
`ifdef RST_SEQ_ACK_EN
            || seq_err !== x.er
`endif
           ) begin
          failures++;
          $display("FAIL edge%0d (now %0d): got rn=%b done=%b cur=%0d want rn=%b done=%b cur=%0d",
                   x.e, edge_n, rst_n_out, seq_done, cur_ch, x.rn, x.dn, x.cc);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rst_n_out !== 4'b0000 || seq_done !== 1'b0 || cur_ch !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: got rn=%b done=%b cur=%0d want 0000 0 0",
               rst_n_out, seq_done, cur_ch);
    end
    rst = 1'b0;
    push_seq(SD);
    sb_drain(SD + HOLD + 3 * GAP);
  endtask

  task automatic test_sw_rst;
    push(39, 4'hF, 1'b1, 2'd3);
    sb_drain(39);
    sw_rst_req = 1'b1;
    push(40, 4'h0, 1'b0, 2'd0);
    sb_drain(40);
    sw_rst_req = 1'b0;
    push_seq(40);
    sb_drain(68);
  endtask

  task automatic test_ext_abort;
    sb_drain(69);
    sw_rst_req = 1'b1;
    sb_drain(70);
    sw_rst_req = 1'b0;
    push(86, 4'h1, 1'b0, 2'd1);
    push(90, 4'h3, 1'b0, 2'd2);
    sb_drain(91);
    ext_rst_n = 1'b0;
    push(93, 4'h3, 1'b0, 2'd2);
    push(94, 4'h0, 1'b0, 2'd0);
    sb_drain(94);
    ext_rst_n = 1'b1;
    push(100, 4'h0, 1'b0, 2'd0);
    push_seq(96);
    sb_drain(124);
  endtask

  task automatic test_sw_on_release;
    sb_drain(125);
    sw_rst_req = 1'b1;
    sb_drain(126);
    sw_rst_req = 1'b0;
    push(146, 4'h3, 1'b0, 2'd2);
    push(149, 4'h3, 1'b0, 2'd2);
    sb_drain(149);
    sw_rst_req = 1'b1;
    push(150, 4'h0, 1'b0, 2'd0);
    sb_drain(150);
    sw_rst_req = 1'b0;
    checks++;
    if (rst_n_out[2] !== 1'b0) begin
      failures++;
      $display("FAIL sw_vs_release_ch2: got %b want 0", rst_n_out[2]);
    end
    push_seq(150);
    sb_drain(178);
  endtask

  task automatic test_glitch;
    sb_drain(180);
    ext_rst_n = 1'b0;
    push(182, 4'hF, 1'b1, 2'd3);
    push(183, 4'h0, 1'b0, 2'd0);
    sb_drain(186);
    ext_rst_n = 1'b1;
    sb_drain(187);
    ext_rst_n = 1'b0;
    for (int e = 188; e <= 200; e++) push(e, 4'h0, 1'b0, 2'd0);
    sb_drain(200);
    ext_rst_n = 1'b1;
    push_seq(202);
    sb_drain(230);
  endtask

`ifdef RST_SEQ_ACK_EN
  task automatic test_ack_timeout;
    ch_ack = 4'b1101;
    sb_drain(231);
    sw_rst_req = 1'b1;
    sb_drain(232);
    sw_rst_req = 1'b0;
    push(252, 4'h3, 1'b0, 2'd2);
    push(315, 4'h3, 1'b0, 2'd2);
    exp_err = 1'b1;
    push(316, 4'h7, 1'b0, 2'd3);
    push(320, 4'hF, 1'b1, 2'd3);
    sb_drain(329);
    sw_rst_req = 1'b1;
    push(330, 4'h0, 1'b0, 2'd0);
    sb_drain(330);
    sw_rst_req = 1'b0;
    push(335, 4'h0, 1'b0, 2'd0);
    sb_drain(335);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_sw_rst;
    test_ext_abort;
    test_sw_on_release;
    test_glitch;
`ifdef RST_SEQ_ACK_EN
    test_ack_timeout;
`endif
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
